// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one MAIN_MEMORY port between the instruction and data caches.
// Round-robin grant, request held on the memory port until DONE, one-cycle DONE/ERROR
// reported back to the owner, and a watchdog for memory that never completes.
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int TIMEOUT          = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  i_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       i_vis_addr,
    output logic [LEN-1:0]              i_data,
    output logic [1:0]                  i_status,
    input  logic [1:0]                  d_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       d_vis_addr,
    input  logic [LEN-1:0]              d_writen_data,
    input  logic [ENTRY_INDEX_SIZE:0]   d_write_length,
    output logic [LEN-1:0]              d_data,
    output logic [1:0]                  d_status,
    output logic [1:0]                  mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    output logic [LEN-1:0]              mem_writen_data,
    output logic [ENTRY_INDEX_SIZE:0]   mem_length,
    input  logic [LEN-1:0]              mem_data,
    input  logic [1:0]                  mem_status
);

    // Last watchdog value before giving up: a grant lasts at most TIMEOUT cycles.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP, ERR} state_t;

    state_t     state, state_nx;
    logic       owner_d;     // 1: D-cache owns the memory port
    logic       last_d;      // 1: last grant went to D-cache
    logic       abort;       // owner dropped its request during the grant
    logic [7:0] wdog;

    logic       i_act, d_act, grant_i, grant_d, owner_act, mem_done, wdog_exp;
    logic [1:0] owner_status, other_status;

    // 01 and 10 are requests; 00 and 11 are idle.
    assign i_act     = i_vis_signal[0] ^ i_vis_signal[1];
    assign d_act     = d_vis_signal[0] ^ d_vis_signal[1];
    assign grant_d   = d_act && (!i_act || !last_d);
    assign grant_i   = i_act && !grant_d;
    assign owner_act = owner_d ? d_act : i_act;
    assign mem_done  = (mem_status == 2'b10);
    assign wdog_exp  = (wdog == WDOG_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode and per-port status reporting.
    always_comb begin
        state_nx     = state;
        owner_status = 2'b00;
        other_status = 2'b00;
        case (state)
            IDLE: begin
                if (grant_d)      state_nx = GRANT_D;
                else if (grant_i) state_nx = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                owner_status = (owner_act && !abort) ? 2'b01 : 2'b00;
                if (mem_done)      state_nx = RESP;
                else if (wdog_exp) state_nx = ERR;
            end
            RESP: begin
                owner_status = abort ? 2'b00 : 2'b10;
                state_nx     = IDLE;
            end
            ERR: begin
                owner_status = abort ? 2'b00 : 2'b11;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The waiting port sees busy only while the other port holds memory.
        if (state != IDLE)
            other_status = (owner_d ? i_act : d_act) ? 2'b01 : 2'b00;
        i_status = owner_d ? other_status : owner_status;
        d_status = owner_d ? owner_status : other_status;
    end

    // Ownership, watchdog, memory-port request registers and returned read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d         <= 1'b0;
            last_d          <= 1'b0;
            abort           <= 1'b0;
            wdog            <= 8'd0;
            mem_vis_signal  <= 2'b00;
            mem_vis_addr    <= '0;
            mem_writen_data <= '0;
            mem_length      <= '0;
            i_data          <= '0;
            d_data          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog  <= 8'd0;
                    abort <= 1'b0;
                    if (grant_d) begin
                        owner_d         <= 1'b1;
                        last_d          <= 1'b1;
                        mem_vis_signal  <= d_vis_signal;
                        mem_vis_addr    <= d_vis_addr;
                        mem_writen_data <= d_writen_data;
                        mem_length      <= d_write_length;
                    end else if (grant_i) begin
                        owner_d         <= 1'b0;
                        last_d          <= 1'b0;
                        mem_vis_signal  <= i_vis_signal;
                        mem_vis_addr    <= i_vis_addr;
                        mem_writen_data <= '0;
                        mem_length      <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    wdog <= wdog + 8'd1;
                    if (!owner_act) abort <= 1'b1;
                    if (mem_done) begin
                        mem_vis_signal <= 2'b00;
                        // Only reads return data; writes leave the port's data untouched.
                        if (mem_vis_signal == 2'b01) begin
                            if (owner_d) d_data <= mem_data;
                            else         i_data <= mem_data;
                        end
                    end else if (wdog_exp) begin
                        mem_vis_signal <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a request/response scoreboard for mem_arbiter.
module tb_mem_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_vis_signal, d_vis_signal, mem_vis_signal, mem_status;
    logic [1:0]    i_status, d_status;
    logic [AW-1:0] i_vis_addr, d_vis_addr, mem_vis_addr;
    logic [DW-1:0] i_data, d_data, d_writen_data, mem_writen_data, mem_data;
    logic [EW:0]   d_write_length, mem_length;

    mem_arbiter #(.ADDR_WIDTH(AW), .LEN(DW), .ENTRY_INDEX_SIZE(EW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .i_vis_signal(i_vis_signal), .i_vis_addr(i_vis_addr), .i_data(i_data), .i_status(i_status),
        .d_vis_signal(d_vis_signal), .d_vis_addr(d_vis_addr), .d_writen_data(d_writen_data),
        .d_write_length(d_write_length), .d_data(d_data), .d_status(d_status),
        .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
        .mem_writen_data(mem_writen_data), .mem_length(mem_length),
        .mem_data(mem_data), .mem_status(mem_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    sig;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [EW:0]   len;
    } req_t;

    typedef struct {
        bit            is_d;
        logic [1:0]    st;
        logic [DW-1:0] data;
    } resp_t;

    req_t          exp_req[$];
    resp_t         exp_resp[$];
    logic [DW-1:0] rdata_q[$];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            mem_delay = 4;
    bit            mem_hang = 0;
    int            mcnt = 0;
    logic [1:0]    prev_sig = 2'b00;
    logic [DW-1:0] d_last = '0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_req(input logic [1:0] s, input logic [AW-1:0] a,
                            input logic [DW-1:0] w, input logic [EW:0] l);
        req_t r;
        r.sig = s; r.addr = a; r.wdata = w; r.len = l;
        exp_req.push_back(r);
    endtask

    task automatic push_resp(input bit is_d, input logic [1:0] st, input logic [DW-1:0] data);
        resp_t r;
        r.is_d = is_d; r.st = st; r.data = data;
        exp_resp.push_back(r);
    endtask

    task automatic check_resp(input bit is_d, input logic [1:0] st, input logic [DW-1:0] data);
        resp_t r;
        n_cmp++;
        if (exp_resp.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_resp port_d=%0d status=%0h data=%0h", is_d, st, data);
        end else begin
            r = exp_resp.pop_front();
            if (r.is_d != is_d || r.st !== st || r.data !== data) begin
                n_bad++;
                $display("FAIL resp got port_d=%0d st=%0h data=%0h expected port_d=%0d st=%0h data=%0h",
                         is_d, st, data, r.is_d, r.st, r.data);
            end
        end
    endtask

    // Memory model: busy while requested, DONE after mem_delay cycles unless hung.
    always @(negedge clk) begin
        if (rst) begin
            mem_status = 2'b00;
            mcnt = 0;
        end else if (mem_status == 2'b10) begin
            mem_status = 2'b00;
            mcnt = 0;
        end else if (mem_vis_signal != 2'b00) begin
            mcnt++;
            if (!mem_hang && mcnt >= mem_delay) begin
                mem_status = 2'b10;
                mem_data   = (rdata_q.size() > 0) ? rdata_q.pop_front() : '0;
            end else begin
                mem_status = 2'b01;
            end
        end else begin
            mem_status = 2'b00;
            mcnt = 0;
        end
    end

    // Monitor: checks each new memory request and each DONE/ERROR against the queues.
    always @(posedge clk) begin
        req_t r;
        #1;
        if (!rst) begin
            if (mem_vis_signal != 2'b00 && prev_sig == 2'b00) begin
                n_cmp++;
                if (exp_req.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_req sig=%0h addr=%0h", mem_vis_signal, mem_vis_addr);
                end else begin
                    r = exp_req.pop_front();
                    if (mem_vis_signal !== r.sig || mem_vis_addr !== r.addr ||
                        mem_writen_data !== r.wdata || mem_length !== r.len) begin
                        n_bad++;
                        $display("FAIL mem_req got sig=%0h addr=%0h wdata=%0h len=%0h expected sig=%0h addr=%0h wdata=%0h len=%0h",
                                 mem_vis_signal, mem_vis_addr, mem_writen_data, mem_length,
                                 r.sig, r.addr, r.wdata, r.len);
                    end
                end
            end
            if (i_status[1]) check_resp(1'b0, i_status, i_data);
            if (d_status[1]) check_resp(1'b1, d_status, d_data);
        end
        prev_sig = mem_vis_signal;
    end

    // Wait for DONE/ERROR on a port, then deassert that port's request.
    task automatic wait_done(input bit is_d);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (is_d ? d_status[1] : i_status[1]) begin
                if (is_d) d_vis_signal = 2'b00;
                else      i_vis_signal = 2'b00;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_done_timeout port_d=%0d", is_d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        i_vis_signal = 2'b00; i_vis_addr = '0;
        d_vis_signal = 2'b00; d_vis_addr = '0; d_writen_data = '0; d_write_length = '0;
        mem_status = 2'b00; mem_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_vis_signal", 32'(mem_vis_signal), 0);
        chk("rst_mem_vis_addr",   32'(mem_vis_addr), 0);
        chk("rst_mem_wdata",      mem_writen_data, 0);
        chk("rst_statuses",       32'({i_status, d_status}), 0);
        chk("rst_i_data",         i_data, 0);
        chk("rst_d_data",         d_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: D first, I waits busy, then I.
        push_req(2'b01, 17'h00030, 0, 0); push_req(2'b01, 17'h00020, 0, 0);
        rdata_q.push_back(32'hD0D0_0001); rdata_q.push_back(32'h1111_0002);
        push_resp(1'b1, 2'b10, 32'hD0D0_0001); push_resp(1'b0, 2'b10, 32'h1111_0002);
        i_vis_signal = 2'b01; i_vis_addr = 17'h00020;
        d_vis_signal = 2'b01; d_vis_addr = 17'h00030;
        @(negedge clk);
        chk("tie_first_owner_addr", 32'(mem_vis_addr), 32'h30);
        chk("tie_i_busy", 32'(i_status), 1);
        wait_done(1'b1);
        wait_done(1'b0);
        @(negedge clk);

        // Second tie: last grant was I, so D goes first again.
        push_req(2'b01, 17'h00034, 0, 0); push_req(2'b01, 17'h00024, 0, 0);
        rdata_q.push_back(32'hD0D0_0003); rdata_q.push_back(32'h1111_0004);
        push_resp(1'b1, 2'b10, 32'hD0D0_0003); push_resp(1'b0, 2'b10, 32'h1111_0004);
        i_vis_signal = 2'b01; i_vis_addr = 17'h00024;
        d_vis_signal = 2'b01; d_vis_addr = 17'h00034;
        wait_done(1'b1);
        wait_done(1'b0);
        d_last = 32'hD0D0_0003;
        @(negedge clk);

        // Single I read: request visible one edge later, data held afterwards.
        push_req(2'b01, 17'h00010, 0, 0);
        rdata_q.push_back(32'hDEAD_BEEF);
        push_resp(1'b0, 2'b10, 32'hDEAD_BEEF);
        i_vis_signal = 2'b01; i_vis_addr = 17'h00010;
        @(posedge clk); #1;
        chk("i_read_latency", 32'(mem_vis_signal), 1);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        chk("i_data_held", i_data, 32'hDEAD_BEEF);
        chk("i_status_idle", 32'(i_status), 0);

        // D write: fields forwarded, DONE reported, d_data unchanged.
        push_req(2'b10, 17'h00100, 32'h1234_5678, 4'd4);
        rdata_q.push_back(32'hBAD0_BAD0);
        push_resp(1'b1, 2'b10, d_last);
        d_vis_signal = 2'b10; d_vis_addr = 17'h00100;
        d_writen_data = 32'h1234_5678; d_write_length = 4'd4;
        wait_done(1'b1);
        d_writen_data = '0; d_write_length = '0;
        @(negedge clk);

        // Watchdog: memory never completes.
        mem_hang = 1;
        push_req(2'b01, 17'h00200, 0, 0);
        push_resp(1'b1, 2'b11, d_last);
        d_vis_signal = 2'b01; d_vis_addr = 17'h00200;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (d_status == 2'b11) break;
            if (mem_vis_signal != 2'b00) cnt++;
        end
        chk("wdog_wait_cycles", 32'(cnt), 255);
        chk("wdog_mem_signal_off", 32'(mem_vis_signal), 0);
        d_vis_signal = 2'b00;
        mem_hang = 0;
        @(negedge clk);
        chk("wdog_back_idle", 32'(d_status), 0);

        // Asynchronous reset while D is granted.
        mem_hang = 1;
        push_req(2'b01, 17'h00300, 0, 0);
        d_vis_signal = 2'b01; d_vis_addr = 17'h00300;
        repeat (3) @(negedge clk);
        chk("pre_rst_d_busy", 32'(d_status), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_mem_signal", 32'(mem_vis_signal), 0);
        chk("async_rst_d_status", 32'(d_status), 0);
        chk("async_rst_d_data", d_data, 0);
        d_vis_signal = 2'b00;
        mem_hang = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_req(2'b01, 17'h00044, 0, 0);
        rdata_q.push_back(32'h4444_0044);
        push_resp(1'b0, 2'b10, 32'h4444_0044);
        i_vis_signal = 2'b01; i_vis_addr = 17'h00044;
        wait_done(1'b0);
        @(negedge clk);

        // I abandons its request mid-grant; memory still completes, D served next.
        mem_delay = 6;
        push_req(2'b01, 17'h00048, 0, 0); push_req(2'b01, 17'h00050, 0, 0);
        rdata_q.push_back(32'h4848_0048); rdata_q.push_back(32'h5050_0050);
        push_resp(1'b1, 2'b10, 32'h5050_0050);
        i_vis_signal = 2'b01; i_vis_addr = 17'h00048;
        @(negedge clk);
        chk("drop_i_busy", 32'(i_status), 1);
        @(negedge clk);
        i_vis_signal = 2'b00;
        d_vis_signal = 2'b01; d_vis_addr = 17'h00050;
        @(negedge clk);
        chk("drop_d_waiting_busy", 32'(d_status), 1);
        wait_done(1'b1);
        mem_delay = 4;
        repeat (3) @(negedge clk);
        chk("req_queue_drained", 32'(exp_req.size()), 0);
        chk("resp_queue_drained", 32'(exp_resp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
